// File: rtl/pdm_combined_filter.sv
// Purpose: PDM-to-PCM CIC decimator (ORDER stages, decimate by DECIM) with saturated signed OUT_W output.
// Latency: output strobe on the 2nd edge after the window's closing accept (3rd with PDM_CIC_COMP_EN).
// Backpressure: none; input ready is held high after reset and downstream must take every strobe.
//
// Ports:
//   clk_clk, reset_reset_n                 - clock, async active-low reset
//   av_st_in_data/valid/ready/error        - 2-bit signed PDM sample sink (01=+1, 11=-1, 00=0, 10=illegal)
//   av_st_out_data/valid/error             - PCM source; error bit0 = bad input in window, bit1 = saturation
// Optional: define PDM_CIC_COMP_EN to add a 3-tap output-rate droop compensator (+1 cycle latency).

module pdm_combined_filter #(
    parameter int DECIM = 64,
    parameter int ORDER = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       av_st_in_data,
    input  logic             av_st_in_valid,
    output logic             av_st_in_ready,
    input  logic [1:0]       av_st_in_error,
    output logic [OUT_W-1:0] av_st_out_data,
    output logic             av_st_out_valid,
    output logic [1:0]       av_st_out_error
);
    localparam int LOG2D = $clog2(DECIM);
    localparam int G     = ORDER * LOG2D;
    localparam int W     = 2 + G;
    localparam int SHR   = G - (OUT_W - 1);
    localparam int RSH   = (SHR > 0) ? SHR : 0;
    localparam int LSH   = (SHR < 0) ? -SHR : 0;
    localparam int SW    = W + LSH;
    // Wide enough for the left-shifted comb output and for the compensator numerator (|12*y| < 2^(OUT_W+4)).
    localparam int FW    = (SW > OUT_W + 5) ? SW : OUT_W + 5;

    // Returns {saturated_flag, clipped_value}. In range iff all bits from the sign down to OUT_W-1 agree.
    function automatic logic [OUT_W:0] saturate(input logic signed [FW-1:0] v);
        logic [FW-OUT_W:0] hi;
        hi = v[FW-1:OUT_W-1];
        if ((&hi) || (~|hi)) begin
            return {1'b0, v[OUT_W-1:0]};
        end else if (v[FW-1]) begin
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    // ------------------------------------------------------------------ state
    logic                    ready_q, ready_d;
    logic [LOG2D-1:0]        cnt_q, cnt_d;
    logic signed [W-1:0]     integ_q [ORDER];
    logic signed [W-1:0]     integ_d [ORDER];
    logic                    err_acc_q, err_acc_d;
    logic                    close_q, close_d;
    logic                    win_err_q, win_err_d;
    logic signed [W-1:0]     prev_q [ORDER];
    logic signed [W-1:0]     prev_d [ORDER];
    logic signed [W-1:0]     comb_q, comb_d;
    logic                    comb_vld_q, comb_vld_d;
    logic                    comb_err_q, comb_err_d;
    logic signed [OUT_W-1:0] y_dat_q, y_dat_d;
    logic                    y_vld_q, y_vld_d;
    logic [1:0]              y_err_q, y_err_d;

    logic                    in_acc;
    logic                    in_bad;
    logic signed [W-1:0]     in_x;
    logic signed [W-1:0]     comb_acc;
    logic signed [FW-1:0]    scaled;
    logic [OUT_W:0]          sat_y;

    // ------------------------------------------------------- input decode
    always_comb begin
        in_acc = av_st_in_valid && ready_q;
        in_bad = (|av_st_in_error) || (av_st_in_data == 2'b10);
        in_x   = '0;
        if (!in_bad) begin
            in_x = {{(W-2){av_st_in_data[1]}}, av_st_in_data};
        end
    end

    // ------------------------------------- integrators and window counter
    always_comb begin
        ready_d   = 1'b1;
        integ_d   = integ_q;
        cnt_d     = cnt_q;
        err_acc_d = err_acc_q;
        close_d   = 1'b0;
        win_err_d = win_err_q;
        if (in_acc) begin
            // Full cascade in one edge: each stage adds the already-updated previous stage.
            integ_d[0] = integ_q[0] + in_x;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_d[k-1];
            end
            if (cnt_q == LOG2D'(DECIM - 1)) begin
                cnt_d     = '0;
                close_d   = 1'b1;
                win_err_d = err_acc_q | in_bad;   // closing sample's error belongs to this window
                err_acc_d = 1'b0;
            end else begin
                cnt_d     = cnt_q + 1'b1;
                err_acc_d = err_acc_q | in_bad;
            end
        end
    end

    // ------------------------------------------- combs, one edge after close
    always_comb begin
        prev_d     = prev_q;
        comb_d     = comb_q;
        comb_vld_d = close_q;
        comb_err_d = comb_err_q;
        comb_acc   = integ_q[ORDER-1];
        if (close_q) begin
            for (int k = 0; k < ORDER; k++) begin
                prev_d[k] = comb_acc;
                comb_acc  = comb_acc - prev_q[k];
            end
            comb_d     = comb_acc;
            comb_err_d = win_err_q;
        end
    end

    // ------------------------------------------- scale and saturate
    always_comb begin
        scaled  = (FW'(comb_q) <<< LSH) >>> RSH;
        sat_y   = saturate(scaled);
        y_vld_d = comb_vld_q;
        y_dat_d = y_dat_q;
        y_err_d = y_err_q;
        if (comb_vld_q) begin
            y_dat_d = sat_y[OUT_W-1:0];
            y_err_d = {sat_y[OUT_W], comb_err_q};
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            err_acc_q  <= 1'b0;
            close_q    <= 1'b0;
            win_err_q  <= 1'b0;
            comb_q     <= '0;
            comb_vld_q <= 1'b0;
            comb_err_q <= 1'b0;
            y_dat_q    <= '0;
            y_vld_q    <= 1'b0;
            y_err_q    <= '0;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                prev_q[k]  <= '0;
            end
        end else begin
            ready_q    <= ready_d;
            cnt_q      <= cnt_d;
            err_acc_q  <= err_acc_d;
            close_q    <= close_d;
            win_err_q  <= win_err_d;
            comb_q     <= comb_d;
            comb_vld_q <= comb_vld_d;
            comb_err_q <= comb_err_d;
            y_dat_q    <= y_dat_d;
            y_vld_q    <= y_vld_d;
            y_err_q    <= y_err_d;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
                prev_q[k]  <= prev_d[k];
            end
        end
    end

    assign av_st_in_ready = ready_q;

`ifdef PDM_CIC_COMP_EN
    // y' = (-y[n] + 10*y[n-1] - y[n-2]) >>> 3, taps advance once per output sample.
    logic signed [OUT_W-1:0] tap1_q, tap1_d;
    logic signed [OUT_W-1:0] tap2_q, tap2_d;
    logic signed [OUT_W-1:0] c_dat_q, c_dat_d;
    logic                    c_vld_q, c_vld_d;
    logic [1:0]              c_err_q, c_err_d;
    logic signed [FW-1:0]    comp_num;
    logic signed [FW-1:0]    comp_shr;
    logic [OUT_W:0]          sat_c;

    always_comb begin
        comp_num = (FW'(tap1_q) <<< 3) + (FW'(tap1_q) <<< 1) - FW'(y_dat_q) - FW'(tap2_q);
        comp_shr = comp_num >>> 3;
        sat_c    = saturate(comp_shr);
        tap1_d   = tap1_q;
        tap2_d   = tap2_q;
        c_dat_d  = c_dat_q;
        c_err_d  = c_err_q;
        c_vld_d  = y_vld_q;
        if (y_vld_q) begin
            tap1_d  = y_dat_q;
            tap2_d  = tap1_q;
            c_dat_d = sat_c[OUT_W-1:0];
            c_err_d = {sat_c[OUT_W] | y_err_q[1], y_err_q[0]};
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tap1_q  <= '0;
            tap2_q  <= '0;
            c_dat_q <= '0;
            c_vld_q <= 1'b0;
            c_err_q <= '0;
        end else begin
            tap1_q  <= tap1_d;
            tap2_q  <= tap2_d;
            c_dat_q <= c_dat_d;
            c_vld_q <= c_vld_d;
            c_err_q <= c_err_d;
        end
    end

    assign av_st_out_data  = c_dat_q;
    assign av_st_out_valid = c_vld_q;
    assign av_st_out_error = c_err_q;
`else
    assign av_st_out_data  = y_dat_q;
    assign av_st_out_valid = y_vld_q;
    assign av_st_out_error = y_err_q;
`endif

endmodule

// File: tb/tb_pdm_combined_filter.sv
`timescale 1ns/1ps
module tb_pdm_combined_filter;
    localparam int D = 64;
`ifdef PDM_CIC_COMP_EN
    localparam int LAT       = 3;
    localparam int FIRST_NEG = 187;    // (1498) >>> 3
    localparam int FIRST_POS = -188;   // (-1497) >>> 3
`else
    localparam int LAT       = 2;
    localparam int FIRST_NEG = -1498;  // -C(67,4) = -766480, >>> 9
    localparam int FIRST_POS = 1497;   //  766480 >>> 9
`endif
    localparam int M_ZERO = 0, M_NEG = 1, M_POS = 2, M_ALT = 3, M_ILL = 4, M_ERR = 5;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_dat;
    logic        in_vld;
    logic        in_rdy;
    logic [1:0]  in_err;
    logic [15:0] out_dat;
    logic        out_vld;
    logic [1:0]  out_err;

    pdm_combined_filter #(.DECIM(64), .ORDER(4), .OUT_W(16)) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .av_st_in_data   (in_dat),
        .av_st_in_valid  (in_vld),
        .av_st_in_ready  (in_rdy),
        .av_st_in_error  (in_err),
        .av_st_out_data  (out_dat),
        .av_st_out_valid (out_vld),
        .av_st_out_error (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int          acc_n = 0;

    logic signed [15:0] s_dat[$];
    logic [1:0]         s_err[$];
    int unsigned        s_cyc[$];
    int unsigned        acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_vld === 1'b1) begin
            s_dat.push_back(out_dat);
            s_err.push_back(out_err);
            s_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        s_dat.delete();
        s_err.delete();
        s_cyc.delete();
        acc_cyc.delete();
        acc_n = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        in_vld = 1'b0;
        #1;
        chk("rst_data",  int'($signed(out_dat)), 0);
        chk("rst_valid", int'(out_vld), 0);
        chk("rst_error", int'(out_err), 0);
        chk("rst_ready", int'(in_rdy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", int'(in_rdy), 0);
        @(negedge clk);
        chk("ready_after_edge", int'(in_rdy), 1);
        clear_log();
    endtask

    task automatic send(input logic [1:0] d, input logic [1:0] e, input bit gap);
        in_dat = d;
        in_err = e;
        in_vld = 1'b1;
        acc_n++;
        if (acc_n % D == 0) acc_cyc.push_back(cyc + 1);
        @(negedge clk);
        in_vld = 1'b0;
        in_dat = 2'b00;
        in_err = 2'b00;
        if (gap) @(negedge clk);
    endtask

    task automatic send_win(input int mode, input bit gap);
        logic [1:0] d;
        logic [1:0] e;
        for (int i = 1; i <= D; i++) begin
            e = 2'b00;
            case (mode)
                M_ZERO:  d = 2'b00;
                M_NEG:   d = 2'b11;
                M_POS:   d = 2'b01;
                default: d = (i % 2 == 1) ? 2'b01 : 2'b11;
            endcase
            if (mode == M_ILL && i % 4 == 0) d = 2'b10;
            if (mode == M_ERR && i == D) e = 2'b01;
            send(d, e, gap);
        end
    endtask

    task automatic drain();
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic check_timing(input string tag, input int n, input int spacing);
        chk({tag, "_count"}, s_dat.size(), n);
        for (int j = 0; j < s_cyc.size() && j < acc_cyc.size(); j++)
            chk({tag, "_latency"}, int'(s_cyc[j] - acc_cyc[j]), LAT);
        for (int j = 1; j < s_cyc.size(); j++)
            chk({tag, "_spacing"}, int'(s_cyc[j] - s_cyc[j-1]), spacing);
    endtask

    initial begin
        rst_n  = 1'b1;
        in_vld = 1'b0;
        in_dat = 2'b00;
        in_err = 2'b00;

        // Zeros: data 0, error 0
        do_reset();
        repeat (2) send_win(M_ZERO, 1'b0);
        drain();
        check_timing("zero", 2, D);
        if (s_dat.size() == 2) begin
            chk("zero_d0", int'(s_dat[0]), 0);
            chk("zero_d1", int'(s_dat[1]), 0);
            chk("zero_e1", int'(s_err[1]), 0);
        end

        // Constant -1 (state still all zero after zero input)
        clear_log();
        repeat (7) send_win(M_NEG, 1'b0);
        drain();
        check_timing("neg", 7, D);
        if (s_dat.size() == 7) begin
            chk("neg_first", int'(s_dat[0]), FIRST_NEG);
            chk("neg_d5",    int'(s_dat[5]), -32768);
            chk("neg_d6",    int'(s_dat[6]), -32768);
            chk("neg_e6",    int'(s_err[6]), 0);
        end
        chk("hold_valid", int'(out_vld), 0);
        chk("hold_data",  int'($signed(out_dat)), -32768);

        // Constant +1 saturates
        do_reset();
        repeat (7) send_win(M_POS, 1'b0);
        drain();
        check_timing("pos", 7, D);
        if (s_dat.size() == 7) begin
            chk("pos_first",   int'(s_dat[0]), FIRST_POS);
            chk("pos_first_e", int'(s_err[0]), 0);
            chk("pos_d5",      int'(s_dat[5]), 32767);
            chk("pos_d6",      int'(s_dat[6]), 32767);
            chk("pos_e6",      int'(s_err[6]), 2);
        end

        // Alternating +1/-1, then illegal codes, clean, closing-sample error
        do_reset();
        repeat (7) send_win(M_ALT, 1'b0);
        send_win(M_ILL, 1'b0);
        send_win(M_ALT, 1'b0);
        send_win(M_ERR, 1'b0);
        drain();
        check_timing("alt", 10, D);
        if (s_dat.size() == 10) begin
            chk("alt_d5",        int'(s_dat[5]), 0);
            chk("alt_d6",        int'(s_dat[6]), 0);
            chk("alt_e6",        int'(s_err[6]), 0);
            chk("illegal_err0",  int'(s_err[7][0]), 1);
            chk("clean_err0",    int'(s_err[8][0]), 0);
            chk("closing_err0",  int'(s_err[9][0]), 1);
        end

        // 50% valid duty: same values, strobes twice as far apart
        do_reset();
        repeat (7) send_win(M_NEG, 1'b1);
        drain();
        check_timing("gap", 7, 2 * D);
        if (s_dat.size() == 7) begin
            chk("gap_first", int'(s_dat[0]), FIRST_NEG);
            chk("gap_d5",    int'(s_dat[5]), -32768);
            chk("gap_d6",    int'(s_dat[6]), -32768);
        end

        // Reset mid-window discards the partial window
        clear_log();
        for (int i = 0; i < 30; i++) send(2'b11, 2'b00, 1'b0);
        chk("pre_reset_hold", int'($signed(out_dat)), -32768);
        do_reset();
        send_win(M_NEG, 1'b0);
        drain();
        check_timing("midrst", 1, D);
        if (s_dat.size() == 1)
            chk("midrst_first", int'(s_dat[0]), FIRST_NEG);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
